tetris_input_ctrl: RTL and testbench

Command initiator for the tetris game core. Converts raw push-button levels, a gravity timer and garbage-bar requests into single `state_type` commands on the core's `ctrl` / `bar_mask` inputs. It watches the core's `state` output to know when a command is consumed. Sits between the board-level button / UART-decode logic and the game core.

---
 rtl/enum_type.sv | 47 ++++
 rtl/tetris_input_ctrl_btn.sv | 55 +++++
 rtl/tetris_input_ctrl.sv | 170 +++++++++++++++++
 tb/tb_tetris_input_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/enum_type.sv
// enum_type: shared types and constants for the tetris game core and its
// command initiator.
//   state_type  - game core state, also used as the command encoding on ctrl
//   BTN_*       - bit positions of the raw push-button vector
//   BTN_CMD     - command issued for each button index
//   CMD_PRIO    - issue priority, index 0 = highest
//   BTN_REPEAT  - buttons that auto-repeat when TETRIS_CTRL_AUTOREPEAT_EN is set
package enum_type;

    typedef enum logic [3:0] {
        NONE,
        INIT,
        WAIT,
        END,
        NEW,
        CLEAR,
        LEFT,
        RIGHT,
        ROTATE,
        ROTATE_REV,
        DOWN,
        DROP,
        HOLD,
        BAR
    } state_type;

    localparam int NUM_BTN = 7;
    localparam int NUM_CMD = 8;

    localparam int BTN_LEFT       = 0;
    localparam int BTN_RIGHT      = 1;
    localparam int BTN_ROTATE     = 2;
    localparam int BTN_ROTATE_REV = 3;
    localparam int BTN_DOWN       = 4;
    localparam int BTN_DROP       = 5;
    localparam int BTN_HOLD       = 6;

    localparam state_type BTN_CMD [NUM_BTN] =
        '{LEFT, RIGHT, ROTATE, ROTATE_REV, DOWN, DROP, HOLD};

    localparam state_type CMD_PRIO [NUM_CMD] =
        '{HOLD, ROTATE, ROTATE_REV, LEFT, RIGHT, DROP, DOWN, BAR};

    // LEFT, RIGHT and DOWN
    localparam logic [NUM_BTN-1:0] BTN_REPEAT = 7'b001_0011;

endpackage

// File: rtl/tetris_input_ctrl_btn.sv
// tetris_btn: one push-button channel.
//   clk, reset_n - clock, async active-low reset
//   raw          - raw button level (asynchronous)
//   press        - one-cycle request: rising edge, or an auto-repeat beat
// Macro TETRIS_CTRL_AUTOREPEAT_EN: when defined and REPEAT is set, a held
// button re-fires after DAS_CYCLES and then every ARR_CYCLES until release.
module tetris_btn #(
    parameter int unsigned DAS_CYCLES = 15_000_000,
    parameter int unsigned ARR_CYCLES = 3_000_000,
    parameter bit          REPEAT     = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic press
);

    // sync[1:0] is the synchronizer, sync[2] the delayed copy for edge detect
    logic [2:0] sync;
    logic       rise;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync <= '0;
        else          sync <= {sync[1:0], raw};
    end

    assign rise = sync[1] & ~sync[2];

`ifdef TETRIS_CTRL_AUTOREPEAT_EN
    if (REPEAT) begin : g_rpt
        logic [31:0] cnt;
        logic        held;
        logic        fire;

        assign held = sync[1] & sync[2];
        assign fire = held && (cnt == '0);

        // Loaded on the edge so the first repeat lands DAS cycles after the
        // edge-generated request, then reloaded with ARR on every beat.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)  cnt <= '0;
            else if (rise) cnt <= DAS_CYCLES - 32'd1;
            else if (held) cnt <= (cnt == '0) ? ARR_CYCLES - 32'd1 : cnt - 32'd1;
        end

        assign press = rise | fire;
    end else begin : g_norpt
        assign press = rise;
    end
`else
    localparam int unsigned unused_cfg = DAS_CYCLES ^ ARR_CYCLES ^ 32'(REPEAT);
    assign press = rise;
`endif

endmodule

// File: rtl/tetris_input_ctrl.sv
// tetris_input_ctrl: turns button presses, gravity ticks and garbage-bar
// requests into single commands for the game core, one at a time, and
// holds each on ctrl until the core (idle in WAIT/INIT/END) consumes it.
//   clk, reset_n       - clock, async active-low reset
//   btn[6:0]           - raw buttons (LEFT, RIGHT, ROTATE, ROTATE_REV, DOWN, DROP, HOLD)
//   bar_req, bar_in    - garbage request strobe and row mask (1 = hole)
//   state, score       - core state and BCD score
//   ctrl, bar_mask     - command to the core, FIFO head while ctrl == BAR
//   bar_ovf            - pulse: garbage request dropped, FIFO full
//   level              - gravity level (score tens digit)
// Macro TETRIS_CTRL_AUTOREPEAT_EN enables auto-repeat on LEFT/RIGHT/DOWN.
module tetris_input_ctrl
    import enum_type::*;
#(
    parameter int unsigned GRAVITY_BASE = 50_000_000,
    parameter int unsigned GRAVITY_STEP = 4_000_000,
    parameter int unsigned GRAVITY_MIN  = 5_000_000,
    parameter int unsigned DAS_CYCLES   = 15_000_000,
    parameter int unsigned ARR_CYCLES   = 3_000_000,
    parameter int unsigned BAR_DEPTH    = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_BTN-1:0] btn,
    input  logic               bar_req,
    input  logic [9:0]         bar_in,
    input  state_type          state,
    input  logic [15:0]        score,
    output state_type          ctrl,
    output logic [9:0]         bar_mask,
    output logic               bar_ovf,
    output logic [3:0]         level
);

    localparam int AW = $clog2(BAR_DEPTH);
    localparam logic [31:0] G_BASE = GRAVITY_BASE;
    localparam logic [31:0] G_STEP = GRAVITY_STEP;
    localparam logic [31:0] G_MIN  = GRAVITY_MIN;

    logic [NUM_BTN-1:0] press;
    logic [NUM_BTN-1:0] pend;
    logic               grav_pend;
    logic [NUM_CMD-1:0] cmd_pend;
    state_type          next_cmd;
    logic               idle, menu, accept, restart, load, pop;

    logic [31:0] grav_cnt, grav_dec, period;
    logic        grav_tick;

    logic [9:0]  fifo_mem [BAR_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full, push_ok, push;

    logic unused_score;
    assign unused_score = ^{score[15:8], score[3:0]};

    // ---------------------------------------------------------------- buttons
    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        tetris_btn #(
            .DAS_CYCLES (DAS_CYCLES),
            .ARR_CYCLES (ARR_CYCLES),
            .REPEAT     (BTN_REPEAT[g])
        ) u_btn (
            .clk     (clk),
            .reset_n (reset_n),
            .raw     (btn[g]),
            .press   (press[g])
        );
    end

    // ---------------------------------------------------------------- handshake
    assign idle    = state inside {WAIT, INIT, END};
    assign menu    = state inside {INIT, END};
    assign accept  = (ctrl != NONE) && idle;
    assign restart = accept && menu;
    assign load    = (ctrl == NONE) && idle && (next_cmd != NONE);
    assign pop     = accept && (ctrl == BAR);

    // Pending vector in priority order; gravity and BAR are masked in the
    // menu states so only button commands can restart the game.
    always_comb begin
        cmd_pend = '0;
        for (int i = 0; i < NUM_CMD; i++) begin
            for (int b = 0; b < NUM_BTN; b++)
                if (BTN_CMD[b] == CMD_PRIO[i]) cmd_pend[i] = pend[b];
            if (CMD_PRIO[i] == DOWN) cmd_pend[i] = pend[BTN_DOWN] | (grav_pend & ~menu);
            if (CMD_PRIO[i] == BAR)  cmd_pend[i] = ~empty & ~menu;
        end
        next_cmd = NONE;
        for (int i = NUM_CMD - 1; i >= 0; i--)
            if (cmd_pend[i]) next_cmd = CMD_PRIO[i];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    ctrl <= NONE;
        else if (accept) ctrl <= NONE;
        else if (load)   ctrl <= next_cmd;
    end

    // Clearing wins over a same-cycle press: a press on a command that is
    // already pending merges into it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend      <= '0;
            grav_pend <= 1'b0;
        end else begin
            for (int b = 0; b < NUM_BTN; b++) begin
                if (restart || (accept && ctrl == BTN_CMD[b])) pend[b] <= 1'b0;
                else if (press[b])                             pend[b] <= 1'b1;
            end
            if (restart || (accept && ctrl == DOWN)) grav_pend <= 1'b0;
            else if (grav_tick)                      grav_pend <= 1'b1;
        end
    end

    // ---------------------------------------------------------------- gravity
    assign level = score[7:4];

    // Clamp compares against BASE-MIN so the subtraction never wraps.
    always_comb begin
        grav_dec = {28'd0, level} * G_STEP;
        if (G_BASE <= G_MIN || grav_dec > G_BASE - G_MIN) period = G_MIN;
        else                                              period = G_BASE - grav_dec;
    end

    // Ticks when the count would reach 0, so the tick spacing is exactly period.
    assign grav_tick = ~menu && (grav_cnt <= 32'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            grav_cnt <= G_BASE;
        else if (restart || (accept && (ctrl == DROP || ctrl == HOLD)))
            grav_cnt <= period;
        else if (grav_tick)
            grav_cnt <= period;
        else if (!menu)
            grav_cnt <= grav_cnt - 32'd1;
    end

    // ---------------------------------------------------------------- garbage FIFO
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_ok = bar_req && (bar_in != '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push    = push_ok && (!full || pop) && !restart;

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= bar_in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            bar_ovf <= 1'b0;
        end else begin
            bar_ovf <= push_ok && full && !pop;
            if (restart) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign bar_mask = (ctrl == BAR) ? fifo_mem[rd_ptr[AW-1:0]] : '0;

endmodule

// File: tb/tb_tetris_input_ctrl.sv
module tb_tetris_input_ctrl;
    import enum_type::*;

    localparam int BUSY = 2;
`ifdef TETRIS_CTRL_AUTOREPEAT_EN
    localparam int EXP_RPT = 5;
`else
    localparam int EXP_RPT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [6:0]  btn = '0;
    logic        bar_req = 1'b0;
    logic [9:0]  bar_in = '0;
    logic [15:0] score = '0;
    state_type   ctrl;
    logic [9:0]  bar_mask;
    logic        bar_ovf;
    logic [3:0]  level;

    // core model
    state_type st = INIT;
    state_type nxt = INIT;
    state_type req_st = INIT;
    bit        req = 1'b0;
    int        req_busy = 0;
    int        busy = 0;
    int        cyc = 0;

    int        ncmd [16];
    state_type acc_log [512];
    int        acc_n = 0;
    logic [9:0] bar_log [64];
    int        bar_n = 0;
    int        down_t [512];
    int        down_n = 0;

    int tests = 0;
    int fails = 0;

    tetris_input_ctrl #(
        .GRAVITY_BASE (100),
        .GRAVITY_STEP (10),
        .GRAVITY_MIN  (30),
        .DAS_CYCLES   (20),
        .ARR_CYCLES   (5),
        .BAR_DEPTH    (4)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .btn      (btn),
        .bar_req  (bar_req),
        .bar_in   (bar_in),
        .state    (st),
        .score    (score),
        .ctrl     (ctrl),
        .bar_mask (bar_mask),
        .bar_ovf  (bar_ovf),
        .level    (level)
    );

    always #5 clk = ~clk;

    // Model samples the DUT mid-cycle and commits its next state on the edge.
    always @(negedge clk) begin
        if (ctrl != NONE && (st inside {WAIT, INIT, END})) begin
            ncmd[int'(ctrl)]++;
            if (acc_n < 512) begin acc_log[acc_n] = ctrl; acc_n++; end
            if (ctrl == BAR && bar_n < 64) begin bar_log[bar_n] = bar_mask; bar_n++; end
            if (ctrl == DOWN && down_n < 512) begin down_t[down_n] = cyc; down_n++; end
        end
        if (req) begin
            nxt = req_st; busy = req_busy;
        end else if (ctrl != NONE && st == WAIT) begin
            nxt = ctrl; busy = BUSY;
        end else if (ctrl != NONE && (st inside {INIT, END})) begin
            nxt = NEW; busy = BUSY;
        end else if (!(st inside {WAIT, INIT, END})) begin
            if (busy == 0) nxt = WAIT;
            else           busy--;
        end
    end

    always @(posedge clk) begin
        st  <= nxt;
        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic go(input state_type s, input int b = 0);
        req_st = s; req_busy = b; req = 1'b1;
        tick();
        req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, s2, s3, d0, t;
        logic [9:0]  m   [5];
        logic [15:0] sc  [3];
        int          per [3];
        int          lv  [3];
        m   = '{10'h155, 10'h2AA, 10'h0F0, 10'h301, 10'h111};
        sc  = '{16'h0050, 16'h0070, 16'h0090};
        per = '{50, 30, 30};
        lv  = '{5, 7, 9};

        // reset values
        tick(2);
        check("rst_ctrl", int'(ctrl), int'(NONE));
        check("rst_mask", int'(bar_mask), 0);
        check("rst_ovf", int'(bar_ovf), 0);
        check("rst_level", int'(level), 0);
        reset_n = 1'b1;
        tick(2);

        // single press, core in WAIT
        go(WAIT);
        s = ncmd[int'(LEFT)];
        btn[BTN_LEFT] = 1'b1;
        tick(3);
        check("press_lat3", int'(ctrl), int'(NONE));
        tick();
        check("press_ctrl", int'(ctrl), int'(LEFT));
        check("press_mask0", int'(bar_mask), 0);
        tick();
        check("press_ret", int'(ctrl), int'(NONE));
        btn[BTN_LEFT] = 1'b0;
        tick(10);
        check("press_once", ncmd[int'(LEFT)] - s, 1);

        // priority: HOLD beats DROP
        s = acc_n;
        btn[BTN_HOLD] = 1'b1; btn[BTN_DROP] = 1'b1;
        tick(2);
        btn[BTN_HOLD] = 1'b0; btn[BTN_DROP] = 1'b0;
        tick(20);
        check("prio_n", acc_n - s, 2);
        check("prio_1st", int'(acc_log[s]), int'(HOLD));
        check("prio_2nd", int'(acc_log[s+1]), int'(DROP));

        // garbage FIFO filled while in INIT (BAR never issued there)
        go(INIT);
        s = bar_n;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                bar_in = '0; bar_req = 1'b1;
                tick();
                bar_req = 1'b0;
                check("bar_zero_ovf", int'(bar_ovf), 0);
            end
            bar_in = m[i]; bar_req = 1'b1;
            tick();
            bar_req = 1'b0; bar_in = '0;
            check($sformatf("bar_ovf%0d", i), int'(bar_ovf), (i == 4) ? 1 : 0);
        end
        tick();
        check("bar_ovf_clr", int'(bar_ovf), 0);
        check("bar_none_init", bar_n - s, 0);
        go(WAIT);
        tick(40);
        check("bar_cnt", bar_n - s, 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("bar_mask%0d", i), int'(bar_log[s+i]), int'(m[i]));

        // gravity period vs level, including the clamp boundary
        for (int k = 0; k < 3; k++) begin
            score = sc[k];
            tick();
            check($sformatf("level%0d", k), int'(level), lv[k]);
            d0 = down_n; t = 0;
            while (down_n < d0 + 3 && t < 400) begin tick(); t++; end
            if (down_n < d0 + 3)
                check($sformatf("grav_timeout%0d", k), down_n - d0, 3);
            else
                check($sformatf("grav_period%0d", k), down_t[d0+2] - down_t[d0+1], per[k]);
        end
        score = '0;
        go(INIT);

        // restart: pending RIGHT and two FIFO entries discarded
        go(NEW, 60);
        btn[BTN_RIGHT] = 1'b1;
        tick(2);
        btn[BTN_RIGHT] = 1'b0;
        bar_in = 10'h00F; bar_req = 1'b1;
        tick(2);
        bar_req = 1'b0; bar_in = '0;
        tick(4);
        s = ncmd[int'(RIGHT)]; s2 = ncmd[int'(BAR)]; s3 = ncmd[int'(ROTATE)];
        btn[BTN_ROTATE] = 1'b1;
        tick(2);
        btn[BTN_ROTATE] = 1'b0;
        tick(3);
        go(END);
        tick(20);
        check("restart_rot", ncmd[int'(ROTATE)] - s3, 1);
        check("restart_right", ncmd[int'(RIGHT)] - s, 0);
        check("restart_bar", ncmd[int'(BAR)] - s2, 0);

        // auto-repeat: DROP first so gravity stays out of the way
        btn[BTN_DROP] = 1'b1;
        tick(2);
        btn[BTN_DROP] = 1'b0;
        tick(10);
        s = ncmd[int'(RIGHT)];
        btn[BTN_RIGHT] = 1'b1;
        tick(40);
        btn[BTN_RIGHT] = 1'b0;
        tick(20);
        check("repeat_right", ncmd[int'(RIGHT)] - s, EXP_RPT);

        // reset in the middle of a handshake
        s = ncmd[int'(LEFT)];
        btn[BTN_LEFT] = 1'b1;
        tick(4);
        check("midrst_pre", int'(ctrl), int'(LEFT));
        #1 reset_n = 1'b0;
        #1;
        check("midrst_ctrl", int'(ctrl), int'(NONE));
        btn[BTN_LEFT] = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(10);
        check("midrst_nocmd", ncmd[int'(LEFT)] - s, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
